// File: rtl/x25519_dh_sequencer.sv
// Round-robin job scheduler feeding one curve25519 scalar-multiplication core.
// Optional: define X25519_ZERO_CHECK_EN to flag all-zero shared secrets on rsp_err.
module x25519_dh_sequencer #(
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] req_chan,
    input  logic          req_op,
    input  logic [254:0]  req_scalar,
    input  logic [254:0]  req_point,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [CW-1:0] rsp_chan,
    output logic          rsp_op,
    output logic [254:0]  rsp_data,
    output logic          rsp_err,
    output logic          core_start,
    output logic [254:0]  core_scalar,
    output logic [254:0]  core_point,
    input  logic          core_done,
    input  logic [254:0]  core_out,
    output logic          busy
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] GUARD = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [254:0] BASE_POINT = 255'd9;

    logic [2:0]          state;
    logic [CHANNELS-1:0] slot_valid;
    logic [CHANNELS-1:0] slot_op;
    logic [254:0]        slot_scalar [CHANNELS];
    logic [254:0]        slot_point  [CHANNELS];
    logic [CW-1:0]       rr;
    logic [CW-1:0]       cur_chan;
    logic                cur_op;
    logic [CW-1:0]       sel_chan;
    logic                sel_found;
    int unsigned         best_dist;
    logic                chan_free;
    logic                accept;

    // Out-of-range channel numbers never match, so they are never ready.
    always_comb begin
        chan_free = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(req_chan) == i) chan_free = !slot_valid[i];
        end
    end

    assign req_ready = chan_free;
    assign accept    = req_valid && chan_free;

    // Pick the valid slot with the smallest forward distance from rr.
    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        best_dist = CHANNELS;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (slot_valid[i] && ((i + CHANNELS - 32'(rr)) % CHANNELS) < best_dist) begin
                best_dist = (i + CHANNELS - 32'(rr)) % CHANNELS;
                sel_chan  = CW'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            slot_scalar[req_chan] <= req_scalar;
            slot_point[req_chan]  <= req_point;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            slot_valid  <= '0;
            slot_op     <= '0;
            rr          <= '0;
            cur_chan    <= '0;
            cur_op      <= 1'b0;
            core_start  <= 1'b0;
            core_scalar <= '0;
            core_point  <= '0;
            rsp_chan    <= '0;
            rsp_op      <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    // The core may still be finishing a job from before a reset.
                    if (sel_found && core_done) begin
                        state       <= ISSUE;
                        cur_chan    <= sel_chan;
                        cur_op      <= slot_op[sel_chan];
                        core_start  <= 1'b1;
                        core_scalar <= slot_scalar[sel_chan];
                        core_point  <= slot_op[sel_chan] ? slot_point[sel_chan] : BASE_POINT;
                        rr          <= (32'(sel_chan) + 1 == CHANNELS) ? '0 : sel_chan + 1'b1;
                    end
                end
                ISSUE: begin
                    slot_valid[cur_chan] <= 1'b0;
                    state                <= GUARD;
                end
                GUARD: state <= WAIT;
                WAIT: begin
                    if (core_done) begin
                        rsp_chan <= cur_chan;
                        rsp_op   <= cur_op;
`ifdef X25519_ZERO_CHECK_EN
                        if (cur_op && core_out == '0) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                        end else begin
                            rsp_err  <= 1'b0;
                            rsp_data <= core_out;
                        end
`else
                        rsp_err  <= 1'b0;
                        rsp_data <= core_out;
`endif
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                slot_valid[req_chan] <= 1'b1;
                slot_op[req_chan]    <= req_op;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (|slot_valid) || (state != IDLE);

endmodule

// File: tb/tb_x25519_dh_sequencer.sv
// Directed bench for x25519_dh_sequencer with a behavioural X25519 core model.
module tb_x25519_dh_sequencer;
    localparam int CW  = 2;
    localparam int LAT = 8;
    localparam logic [255:0] P = {1'b0, {247{1'b1}}, 8'hed};
`ifdef X25519_ZERO_CHECK_EN
    localparam logic ZERO_ERR = 1'b1;
`else
    localparam logic ZERO_ERR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_chan;
    logic          req_op;
    logic [254:0]  req_scalar;
    logic [254:0]  req_point;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [CW-1:0] rsp_chan;
    logic          rsp_op;
    logic [254:0]  rsp_data;
    logic          rsp_err;
    logic          core_start;
    logic [254:0]  core_scalar;
    logic [254:0]  core_point;
    logic          core_done = 1'b1;
    logic [254:0]  core_out = '0;
    logic          busy;

    logic [1:0]    req_chan3;
    logic          req_ready3, rsp_valid3, rsp_op3, rsp_err3, core_start3, busy3;
    logic [1:0]    rsp_chan3;
    logic [254:0]  rsp_data3, core_scalar3, core_point3;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    logic [254:0] m_res, m_sc, m_pt;
    int           m_cnt = 0;
    logic         m_busy = 1'b0;
    logic         m_chk = 1'b0;

    always #5 clock = ~clock;

    x25519_dh_sequencer #(.CHANNELS(4)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
        .req_op(req_op), .req_scalar(req_scalar), .req_point(req_point),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_chan(rsp_chan),
        .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_start(core_start), .core_scalar(core_scalar), .core_point(core_point),
        .core_done(core_done), .core_out(core_out), .busy(busy)
    );

    x25519_dh_sequencer #(.CHANNELS(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(1'b0), .req_ready(req_ready3), .req_chan(req_chan3),
        .req_op(1'b0), .req_scalar(255'd0), .req_point(255'd0),
        .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_chan(rsp_chan3),
        .rsp_op(rsp_op3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
        .core_start(core_start3), .core_scalar(core_scalar3), .core_point(core_point3),
        .core_done(1'b1), .core_out(255'd0), .busy(busy3)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = {256'd0, a} * {256'd0, b};
        t = t % {256'd0, P};
        return t[255:0];
    endfunction

    function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
        return (a >= b) ? (a - b) : (a + P - b);
    endfunction

    function automatic logic [255:0] finv(input logic [255:0] z);
        logic [255:0] r, base, e;
        r = 256'd1;
        base = z;
        e = P - 256'd2;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = fmul(r, base);
            base = fmul(base, base);
        end
        return r;
    endfunction

    // RFC 7748 Montgomery ladder with scalar clamping.
    function automatic logic [254:0] x25519(input logic [254:0] k_in, input logic [254:0] u_in);
        logic [254:0] k;
        logic [255:0] x1, x2, z2, x3, z3, tmp, a, aa, b, bb, e, c, d, da, cb, res;
        logic swap, kt;
        k = k_in;
        k[2:0] = 3'b000;
        k[254] = 1'b1;
        x1 = {1'b0, u_in};
        if (x1 >= P) x1 = x1 - P;
        x2 = 256'd1; z2 = 256'd0; x3 = x1; z3 = 256'd1; swap = 1'b0;
        for (int t = 254; t >= 0; t--) begin
            kt = k[t];
            swap = swap ^ kt;
            if (swap) begin
                tmp = x2; x2 = x3; x3 = tmp;
                tmp = z2; z2 = z3; z3 = tmp;
            end
            swap = kt;
            a  = fadd(x2, z2);
            aa = fmul(a, a);
            b  = fsub(x2, z2);
            bb = fmul(b, b);
            e  = fsub(aa, bb);
            c  = fadd(x3, z3);
            d  = fsub(x3, z3);
            da = fmul(d, a);
            cb = fmul(c, b);
            x3 = fmul(fadd(da, cb), fadd(da, cb));
            z3 = fmul(x1, fmul(fsub(da, cb), fsub(da, cb)));
            x2 = fmul(aa, bb);
            z2 = fmul(e, fadd(aa, fmul(256'd121665, e)));
        end
        if (swap) begin
            tmp = x2; x2 = x3; x3 = tmp;
            tmp = z2; z2 = z3; z3 = tmp;
        end
        res = fmul(x2, finv(z2));
        return res[254:0];
    endfunction

    // Core model: done stays stale for one cycle after start, then drops for LAT cycles.
    always @(posedge clock) begin
        if (!reset_n) m_chk <= 1'b0;
        if (core_start) begin
            m_res  <= x25519(core_scalar, core_point);
            m_sc   <= core_scalar;
            m_pt   <= core_point;
            m_cnt  <= LAT;
            m_busy <= 1'b1;
            m_chk  <= reset_n;
            starts <= starts + 1;
        end else if (m_busy) begin
            if (m_cnt == LAT) core_done <= 1'b0;
            if (m_cnt == 0) begin
                core_done <= 1'b1;
                core_out  <= m_res;
                m_busy    <= 1'b0;
                if (m_chk && reset_n) begin
                    check("opnd_scalar_stable", 256'(core_scalar), 256'(m_sc));
                    check("opnd_point_stable", 256'(core_point), 256'(m_pt));
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    logic [254:0] last_data;

    task automatic send(input logic [1:0] ch, input logic op, input logic [254:0] sc, input logic [254:0] pt);
        int unsigned n = 0;
        @(negedge clock);
        req_valid = 1'b1; req_chan = ch; req_op = op; req_scalar = sc; req_point = pt;
        while (!req_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) check("send_timeout", 256'(req_ready), 256'(1));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [1:0] ch, input logic op,
                           input logic [254:0] data, input logic err);
        int unsigned n = 0;
        @(negedge clock);
        while (!rsp_valid && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid"}, 256'(rsp_valid), 256'(1));
        check({tag, "_chan"}, 256'(rsp_chan), 256'(ch));
        check({tag, "_op"}, 256'(rsp_op), 256'(op));
        check({tag, "_data"}, 256'(rsp_data), 256'(data));
        check({tag, "_err"}, 256'(rsp_err), 256'(err));
        last_data = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_start();
        int unsigned n = 0;
        while (!core_start && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("start_seen", 256'(core_start), 256'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [254:0] a, b, pub_a, pub_b, ss, d2, snap_data;
        logic [254:0] s [10];
        logic [1:0]   snap_chan;
        logic         snap_op, snap_err, bad_stable, bad_start, bad_busy;
        int           s0;
        int unsigned  n;

        a = 255'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        b = 255'h3141592653589793_2384626433832795_0288419716939937_5105820974944592;
        for (int i = 0; i < 10; i++) s[i] = a + 255'(i * 1000 + 7);

        reset_n = 1'b0; req_valid = 1'b0; req_chan = '0; req_op = 1'b0;
        req_scalar = '0; req_point = '0; rsp_ready = 1'b0; req_chan3 = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", 256'(req_ready), 256'(1));
        check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        check("rst_rsp_fields", 256'({rsp_chan, rsp_op, rsp_err}), 256'(0));
        check("rst_rsp_data", 256'(rsp_data), 256'(0));
        check("rst_core_start", 256'(core_start), 256'(0));
        check("rst_core_ops", 256'(core_scalar | core_point), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        @(negedge clock);
        reset_n = 1'b1;

        req_chan3 = 2'd3;
        #1 check("oor_chan_ready", 256'(req_ready3), 256'(0));
        req_chan3 = 2'd2;
        #1 check("inrange_chan_ready", 256'(req_ready3), 256'(1));

        // Keygen on ch0: issue latency, forced base point, single start pulse
        pub_a = x25519(a, 255'd9);
        s0 = starts;
        send(2'd0, 1'b0, a, 255'h1234);
        check("kg_no_early_start", 256'(core_start), 256'(0));
        @(posedge clock);
        #1;
        check("kg_start", 256'(core_start), 256'(1));
        check("kg_point9", 256'(core_point), 256'(9));
        check("kg_scalar", 256'(core_scalar), 256'(a));
        get_rsp("kg0", 2'd0, 1'b0, pub_a, 1'b0);
        check("kg_one_start", 256'(starts - s0), 256'(1));

        // Full Diffie-Hellman exchange
        pub_b = x25519(b, 255'd9);
        send(2'd1, 1'b0, b, '0);
        get_rsp("kg1", 2'd1, 1'b0, pub_b, 1'b0);
        ss = x25519(a, pub_b);
        send(2'd2, 1'b1, a, pub_b);
        send(2'd3, 1'b1, b, pub_a);
        get_rsp("dh2", 2'd2, 1'b1, ss, 1'b0);
        d2 = last_data;
        get_rsp("dh3", 2'd3, 1'b1, ss, 1'b0);
        check("dh_equal", 256'(last_data), 256'(d2));
        check("dh_nonzero", 256'(last_data != '0), 256'(1));

        // Burst on all channels, then refill ch0 while ch1 runs
        for (int i = 0; i < 4; i++) send(2'(i), 1'b0, s[i], '0);
        get_rsp("rr0", 2'd0, 1'b0, x25519(s[0], 255'd9), 1'b0);
        wait_start();
        send(2'd0, 1'b0, s[4], '0);
        get_rsp("rr1", 2'd1, 1'b0, x25519(s[1], 255'd9), 1'b0);
        get_rsp("rr2", 2'd2, 1'b0, x25519(s[2], 255'd9), 1'b0);
        get_rsp("rr3", 2'd3, 1'b0, x25519(s[3], 255'd9), 1'b0);
        get_rsp("rr0b", 2'd0, 1'b0, x25519(s[4], 255'd9), 1'b0);

        // Response back-pressure for 20 cycles with another job pending
        send(2'd1, 1'b0, s[5], '0);
        send(2'd2, 1'b0, s[6], '0);
        n = 0;
        @(negedge clock);
        while (!rsp_valid && n < 2000) begin
            @(negedge clock);
            n++;
        end
        snap_chan = rsp_chan; snap_op = rsp_op; snap_data = rsp_data; snap_err = rsp_err;
        check("bp_chan", 256'(snap_chan), 256'(1));
        check("bp_data", 256'(snap_data), 256'(x25519(s[5], 255'd9)));
        bad_stable = 1'b0; bad_start = 1'b0; bad_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_chan != snap_chan || rsp_op != snap_op ||
                rsp_data != snap_data || rsp_err != snap_err) bad_stable = 1'b1;
            if (core_start) bad_start = 1'b1;
            if (!busy) bad_busy = 1'b1;
        end
        check("bp_rsp_stable", 256'(bad_stable), 256'(0));
        check("bp_no_start", 256'(bad_start), 256'(0));
        check("bp_busy", 256'(bad_busy), 256'(0));
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        n = 0;
        while (!core_start && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("bp_release_issue", 256'(core_start && n <= 2), 256'(1));
        get_rsp("bp2", 2'd2, 1'b0, x25519(s[6], 255'd9), 1'b0);

        // Low-order peer point
        send(2'd3, 1'b1, a, '0);
        get_rsp("zero_pt", 2'd3, 1'b1, '0, ZERO_ERR);

        // Reset during WAIT, then rr restarts from 0 and stale core_done is waited out
        send(2'd2, 1'b0, s[7], '0);
        wait_start();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        req_chan = 2'd2;
        #1;
        check("mid_rst_rsp_valid", 256'(rsp_valid), 256'(0));
        check("mid_rst_rsp_fields", 256'({rsp_chan, rsp_op, rsp_err}), 256'(0));
        check("mid_rst_rsp_data", 256'(rsp_data), 256'(0));
        check("mid_rst_core", 256'({core_start, core_scalar | core_point}), 256'(0));
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_req_ready", 256'(req_ready), 256'(1));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        send(2'd3, 1'b0, s[8], '0);
        send(2'd1, 1'b0, s[9], '0);
        get_rsp("post_rst1", 2'd1, 1'b0, x25519(s[9], 255'd9), 1'b0);
        get_rsp("post_rst3", 2'd3, 1'b0, x25519(s[8], 255'd9), 1'b0);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
